// File: rtl/mem_copy_engine_if.sv
// Bundles the engine's control, CPU pass-through and RAM-side signals.
// slave = engine side, master = CPU/RAM/environment side.
interface mem_copy_engine_if #(
  parameter int WORD_SIZE = 20,
  parameter int ADDR_SIZE = 16
);
  logic                 start_i;
  logic                 fill_i;
  logic [ADDR_SIZE-1:0] src_i;
  logic [ADDR_SIZE-1:0] dst_i;
  logic [ADDR_SIZE-1:0] len_i;
  logic [WORD_SIZE-1:0] fill_value_i;
  logic                 busy_o;
  logic                 done_o;
  logic [ADDR_SIZE-1:0] cpu_addr_i;
  logic [WORD_SIZE-1:0] cpu_value_i;
  logic                 cpu_write_i;
  logic [ADDR_SIZE-1:0] mem_addr_o;
  logic [WORD_SIZE-1:0] mem_value_o;
  logic                 mem_write_o;
  logic [WORD_SIZE-1:0] mem_value_i;

  modport slave (
    input  start_i, fill_i, src_i, dst_i, len_i, fill_value_i,
    input  cpu_addr_i, cpu_value_i, cpu_write_i, mem_value_i,
    output busy_o, done_o, mem_addr_o, mem_value_o, mem_write_o
  );

  modport master (
    output start_i, fill_i, src_i, dst_i, len_i, fill_value_i,
    output cpu_addr_i, cpu_value_i, cpu_write_i, mem_value_i,
    input  busy_o, done_o, mem_addr_o, mem_value_o, mem_write_o
  );
endinterface

// File: rtl/mem_copy_engine.sv
// RAM copy/fill engine: copy takes 2 cycles/word (read then write), fill 1 cycle/word, done_o one cycle after the last write.
// No backpressure: the RAM accepts every access; while busy the CPU port and start_i are ignored.
module mem_copy_engine #(
  parameter int WORD_SIZE = 20,
  parameter int ADDR_SIZE = 16
) (
  input  logic               clk,
  input  logic               reset,
  mem_copy_engine_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, FILL} state_t;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] src_q, src_d;
  logic [ADDR_SIZE-1:0] dst_q, dst_d;
  logic [ADDR_SIZE-1:0] rem_q, rem_d;
  logic [WORD_SIZE-1:0] fill_val_q, fill_val_d;
  logic                 done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      fill_val_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      fill_val_q <= fill_val_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    src_d           = src_q;
    dst_d           = dst_q;
    rem_d           = rem_q;
    fill_val_d      = fill_val_q;
    done_d          = 1'b0;
    bus.mem_addr_o  = bus.cpu_addr_i;
    bus.mem_value_o = bus.cpu_value_i;
    bus.mem_write_o = bus.cpu_write_i;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          // A zero-length request completes immediately without touching RAM.
          if (bus.len_i == '0) begin
            done_d = 1'b1;
          end else begin
            src_d      = bus.src_i;
            dst_d      = bus.dst_i;
            rem_d      = bus.len_i;
            fill_val_d = bus.fill_value_i;
            state_d    = bus.fill_i ? FILL : READ;
          end
        end
      end
      READ: begin
        bus.mem_addr_o  = src_q;
        bus.mem_value_o = '0;
        bus.mem_write_o = 1'b0;
        state_d         = WRITE;
      end
      WRITE, FILL: begin
        bus.mem_addr_o  = dst_q;
        bus.mem_value_o = (state_q == WRITE) ? bus.mem_value_i : fill_val_q;
        bus.mem_write_o = 1'b1;
        rem_d           = rem_q - 1'b1;
        src_d           = src_q + 1'b1;
        dst_d           = dst_q + 1'b1;
        if (rem_q == ADDR_SIZE'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = (state_q == WRITE) ? READ : FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy_o = (state_q != IDLE);
  assign bus.done_o = done_q;
endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural synchronous RAM.
// Monitors count done pulses and log every RAM write and engine read address.
module tb_mem_copy_engine;
  localparam int W = 20;
  localparam int A = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_copy_engine_if #(.WORD_SIZE(W), .ADDR_SIZE(A)) bus();

  mem_copy_engine #(.WORD_SIZE(W), .ADDR_SIZE(A)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous single-port RAM, read data valid the cycle after the address.
  logic [W-1:0] ram [0:65535];
  logic [W-1:0] rd_q;
  always @(posedge clk) begin
    if (bus.mem_write_o === 1'b1) ram[bus.mem_addr_o] <= bus.mem_value_o;
    rd_q <= ram[bus.mem_addr_o];
  end
  assign bus.mem_value_i = rd_q;

  int           done_cnt = 0;
  int           wr_cnt   = 0;
  logic [A-1:0] wq_a[$];
  logic [W-1:0] wq_d[$];
  logic [A-1:0] rq[$];

  always @(posedge clk) begin
    if (bus.done_o === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.mem_write_o === 1'b1) begin
      wr_cnt <= wr_cnt + 1;
      wq_a.push_back(bus.mem_addr_o);
      wq_d.push_back(bus.mem_value_o);
    end
    if (bus.busy_o === 1'b1 && bus.mem_write_o === 1'b0) rq.push_back(bus.mem_addr_o);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic [A-1:0] a, input logic [W-1:0] v);
    bus.cpu_addr_i  = a;
    bus.cpu_value_i = v;
    bus.cpu_write_i = 1'b1;
    @(negedge clk);
    bus.cpu_write_i = 1'b0;
  endtask

  task automatic cpu_rd(input logic [A-1:0] a, output logic [W-1:0] v);
    bus.cpu_addr_i  = a;
    bus.cpu_write_i = 1'b0;
    @(negedge clk);
    v = bus.mem_value_i;
  endtask

  task automatic go(input logic f, input logic [A-1:0] s, input logic [A-1:0] d,
                    input logic [A-1:0] n, input logic [W-1:0] fv);
    bus.fill_i       = f;
    bus.src_i        = s;
    bus.dst_i        = d;
    bus.len_i        = n;
    bus.fill_value_i = fv;
    bus.start_i      = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_idle(output int bc);
    bc = 0;
    while (bus.busy_o === 1'b1 && bc < 40) begin
      bc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int           bc, dbase, wbase, rbase;
    logic [W-1:0] v;

    reset            = 1'b1;
    bus.start_i      = 1'b0;
    bus.fill_i       = 1'b0;
    bus.src_i        = '0;
    bus.dst_i        = '0;
    bus.len_i        = '0;
    bus.fill_value_i = '0;
    bus.cpu_addr_i   = 16'h1234;
    bus.cpu_value_i  = 20'h00005;
    bus.cpu_write_i  = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rst_done", {31'd0, bus.done_o}, 32'd0);
    chk("rst_pass_addr", {16'd0, bus.mem_addr_o}, 32'h1234);
    chk("rst_pass_val", {12'd0, bus.mem_value_o}, 32'h00005);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Copy 3 words 0x10 -> 0x100
    cpu_wr(16'h0010, 20'h11111);
    cpu_wr(16'h0011, 20'h22222);
    cpu_wr(16'h0012, 20'h33333);
    dbase = done_cnt; wbase = wq_a.size();
    go(1'b0, 16'h0010, 16'h0100, 16'd3, 20'h0);
    wait_idle(bc);
    chk("copy_done_first_idle", {31'd0, bus.done_o}, 32'd1);
    chk("copy_busy_cycles", bc, 32'd6);
    repeat (3) @(negedge clk);
    chk("copy_done_cnt", done_cnt - dbase, 32'd1);
    chk("copy_wr_cnt", wq_a.size() - wbase, 32'd3);
    chk("copy_w0_addr", {16'd0, wq_a[wbase]},   32'h0100);
    chk("copy_w0_data", {12'd0, wq_d[wbase]},   32'h11111);
    chk("copy_w1_addr", {16'd0, wq_a[wbase+1]}, 32'h0101);
    chk("copy_w2_data", {12'd0, wq_d[wbase+2]}, 32'h33333);
    cpu_rd(16'h0101, v);
    chk("copy_ram_101", {12'd0, v}, 32'h22222);

    // Fill 4 words at 0x200, then a second fill started in the done cycle
    dbase = done_cnt; wbase = wq_a.size();
    go(1'b1, 16'h0000, 16'h0200, 16'd4, 20'hABCDE);
    wait_idle(bc);
    chk("fill_busy_cycles", bc, 32'd4);
    chk("fill_done_first_idle", {31'd0, bus.done_o}, 32'd1);
    go(1'b1, 16'h0000, 16'h0210, 16'd1, 20'h00002);
    chk("start_in_done_cycle", {31'd0, bus.busy_o}, 32'd1);
    wait_idle(bc);
    repeat (2) @(negedge clk);
    chk("fill_done_cnt", done_cnt - dbase, 32'd2);
    chk("fill_wr_cnt", wq_a.size() - wbase, 32'd5);
    chk("fill_w0_addr", {16'd0, wq_a[wbase]},   32'h0200);
    chk("fill_w3_addr", {16'd0, wq_a[wbase+3]}, 32'h0203);
    chk("fill_w3_data", {12'd0, wq_d[wbase+3]}, 32'hABCDE);
    chk("fill2_addr",   {16'd0, wq_a[wbase+4]}, 32'h0210);
    chk("fill2_data",   {12'd0, wq_d[wbase+4]}, 32'h00002);

    // Wrapping, overlapping copy 0xFFFE -> 0x0000
    cpu_wr(16'hFFFE, 20'h0AAAA);
    cpu_wr(16'hFFFF, 20'h0BBBB);
    cpu_wr(16'h0000, 20'h0CCCC);
    wbase = wq_a.size(); rbase = rq.size();
    go(1'b0, 16'hFFFE, 16'h0000, 16'd3, 20'h0);
    wait_idle(bc);
    @(negedge clk);
    chk("wrap_rd_cnt", rq.size() - rbase, 32'd3);
    chk("wrap_rd0", {16'd0, rq[rbase]},   32'hFFFE);
    chk("wrap_rd1", {16'd0, rq[rbase+1]}, 32'hFFFF);
    chk("wrap_rd2", {16'd0, rq[rbase+2]}, 32'h0000);
    chk("wrap_w2_addr", {16'd0, wq_a[wbase+2]}, 32'h0002);
    chk("wrap_w1_data", {12'd0, wq_d[wbase+1]}, 32'h0BBBB);
    chk("wrap_w2_data", {12'd0, wq_d[wbase+2]}, 32'h0AAAA);

    // Zero length
    dbase = done_cnt; wbase = wq_a.size();
    go(1'b0, 16'h0010, 16'h0400, 16'd0, 20'h0);
    chk("len0_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("len0_done", {31'd0, bus.done_o}, 32'd1);
    @(negedge clk);
    chk("len0_done_drop", {31'd0, bus.done_o}, 32'd0);
    repeat (2) @(negedge clk);
    chk("len0_no_write", wq_a.size() - wbase, 32'd0);
    chk("len0_done_cnt", done_cnt - dbase, 32'd1);

    // Lockout: CPU write, second start and input changes during busy
    cpu_wr(16'h0300, 20'h12345);
    dbase = done_cnt; wbase = wq_a.size();
    go(1'b0, 16'h0010, 16'h0120, 16'd2, 20'h0);
    bus.cpu_addr_i   = 16'h0300;
    bus.cpu_value_i  = 20'h77777;
    bus.cpu_write_i  = 1'b1;
    bus.start_i      = 1'b1;
    bus.fill_i       = 1'b1;
    bus.dst_i        = 16'h0500;
    bus.len_i        = 16'd5;
    bus.fill_value_i = 20'h55555;
    repeat (2) @(negedge clk);
    bus.cpu_write_i = 1'b0;
    bus.start_i     = 1'b0;
    wait_idle(bc);
    repeat (3) @(negedge clk);
    chk("lock_done_cnt", done_cnt - dbase, 32'd1);
    chk("lock_wr_cnt", wq_a.size() - wbase, 32'd2);
    cpu_rd(16'h0300, v);
    chk("lock_ram_300", {12'd0, v}, 32'h12345);
    cpu_rd(16'h0121, v);
    chk("lock_ram_121", {12'd0, v}, 32'h22222);

    // Reset in the second WRITE of a 5-word copy
    dbase = done_cnt; wbase = wq_a.size();
    go(1'b0, 16'h0010, 16'h0180, 16'd5, 20'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("abort_mem_write", {31'd0, bus.mem_write_o}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.cpu_addr_i = 16'h4321;
    #1;
    chk("abort_pass_addr", {16'd0, bus.mem_addr_o}, 32'h4321);
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_cnt - dbase, 32'd0);
    chk("abort_wr_1or2", {31'd0, ((wq_a.size() - wbase) == 1) || ((wq_a.size() - wbase) == 2)}, 32'd1);
    cpu_rd(16'h0180, v);
    chk("abort_ram_180", {12'd0, v}, 32'h11111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
